md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit and its sequencer for the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers. Accepts mult/multu/div/divu/mthi/mtlo from E.
- Models fixed multi-cycle latency with a busy counter.
- Produces the stall request that the hazard unit uses to freeze F/D while an md-dependent instruction sits in D. E-stage write-data selection reads HI/LO from this block (mfhi/mflo).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- MDOpE  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- AE  input  32  forwarded rs value of E-stage instruction
- BE  input  32  forwarded rt value of E-stage instruction
- MDUseD  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- HI  output  32  current HI register
- LO  output  32  current LO register
- Busy  output  1  operation in flight
- StallMD  output  1  stall request to hazard unit

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset. When reset is sampled high: HI=0, LO=0, counter=0, Busy=0, pending result regs=0, state IDLE. Reset mid-operation aborts the op; no HI/LO commit occurs.
- States: IDLE (counter==0), RUN (counter>0). Busy = (state==RUN).
- Start (ops 1-4), sampled in IDLE on rising edge at end of cycle t:
  - Result is computed combinationally from AE/BE in cycle t and latched into pendHI/pendLO.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state goes to RUN.
  - Busy=1 during cycles t+1 .. t+N.
  - On the edge ending cycle t+N: HI<=pendHI, LO<=pendLO, counter reaches 0, state goes to IDLE. New values are visible from cycle t+N+1.
- Start while RUN is ignored. The hazard unit guarantees this cannot occur; the bench checks that HI/LO and counter are unaffected.
- Arithmetic rules:
  - mult: signed 32x32 to 64-bit product, {HI,LO}.
  - multu: unsigned 32x32 to 64-bit product, {HI,LO}.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (BE==0): counter still runs DIV_CYCLES and Busy behaves normally; HI/LO are NOT updated at completion.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- mthi/mtlo (ops 5/6): in IDLE, HI or LO <= AE on the same edge, single cycle, Busy stays 0. In RUN they are ignored, as the hazard unit prevents this.
- StallMD = MDUseD & (Busy | MDOpE is start op 1-4). Purely combinational, no latency.
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES)+1). It never wraps, saturating at 0.

Decomposition:
- Shared package: MDOp encoding constants (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO); also the ALU/WDSel constants the E stage uses.
- One sub-module: md_arith, combinational. Inputs op, A, B; outputs res_hi, res_lo, div_zero.
- The sequencer (counter, state, HI/LO, stall) stays in md_unit.

Test Plan:
- Signed mult: AE=0xFFFFFFFF, BE=2, MDOpE=mult for 1 cycle. Expect Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned mult and divu:
  - multu same operands: HI=0x00000001, LO=0xFFFFFFFE.
  - divu 7/2: Busy for 10 cycles, then LO=3, HI=1.
- Signed div: AE=0xFFFFFFF9 (-7), BE=2. Expect LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles.
- Divide by zero: HI=0x11, LO=0x22 preloaded via mthi/mtlo (each updates next cycle, Busy stays 0), then div AE=5, BE=0. Expect Busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- Stall: MDUseD=1 in start cycle and during busy. Expect StallMD=1 in start cycle and all 5 busy cycles, StallMD=0 the cycle after. Also: a start or mthi issued while Busy leaves HI/LO/counter unchanged.
- Reset mid-op: start mult 3*4, assert reset in 3rd busy cycle. Expect next cycle Busy=0, HI=0, LO=0; no later commit of 12.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide path: MDOp codes, sequencer
// states and the ALU / write-data select constants the E stage decodes.
package md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_LUI  = 3'd5;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_HI    = 2'd1;
    localparam logic [1:0] WD_LO    = 2'd2;
    localparam logic [1:0] WD_PC8   = 2'd3;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } mdState_e;

    // Ops 1-4 occupy the unit for several cycles; mthi/mtlo do not.
    function automatic logic isStartOp(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational datapath of the md unit: 64-bit products and quotient/remainder
// pairs, formatted as the values that will land in HI and LO.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [31:0] divisor;
    logic [31:0] qMag;
    logic [31:0] rMag;
    logic        isSignedDiv;

    // Signed division works on magnitudes so 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 without ever evaluating an overflowing signed divide.
    always_comb begin
        isSignedDiv = (op == MD_DIV);
        aMag        = (isSignedDiv && A[31]) ? (32'd0 - A) : A;
        bMag        = (isSignedDiv && B[31]) ? (32'd0 - B) : B;
        divisor     = (bMag == 32'd0) ? 32'd1 : bMag;
        qMag        = aMag / divisor;
        rMag        = aMag % divisor;
        prod        = 64'd0;
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        case (op)
            MD_MULT: begin
                prod   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_MULTU: begin
                prod   = {32'd0, A} * {32'd0, B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_DIV: begin
                res_hi = A[31] ? (32'd0 - rMag) : rMag;
                res_lo = (A[31] ^ B[31]) ? (32'd0 - qMag) : qMag;
            end
            MD_DIVU: begin
                res_hi = rMag;
                res_lo = qMag;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
        div_zero = (B == 32'd0) && ((op == MD_DIV) || (op == MD_DIVU));
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide sequencer: owns HI/LO, models fixed op latency with a
// down-counter and raises the F/D stall while an md-dependent op waits in D.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] AE,
    input  logic [31:0] BE,
    input  logic        MDUseD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        StallMD
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdState_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pendHi_q, pendHi_d;
    logic [31:0]      pendLo_q, pendLo_d;
    logic             pendZero_q, pendZero_d;

    logic [31:0]      resHi;
    logic [31:0]      resLo;
    logic             divZero;
    logic             isStart;

    md_arith uArith (
        .op       (MDOpE),
        .A        (AE),
        .B        (BE),
        .res_hi   (resHi),
        .res_lo   (resLo),
        .div_zero (divZero)
    );

    assign isStart = isStartOp(MDOpE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pendHi_q   <= 32'd0;
            pendLo_q   <= 32'd0;
            pendZero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pendHi_q   <= pendHi_d;
            pendLo_q   <= pendLo_d;
            pendZero_q <= pendZero_d;
        end
    end

    // Ops arriving while RUN are dropped; the result is latched at start and
    // only committed on the final busy edge, unless it was a divide by zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pendHi_d   = pendHi_q;
        pendLo_d   = pendLo_q;
        pendZero_d = pendZero_q;
        case (state_q)
            MD_IDLE: begin
                if (isStart) begin
                    state_d    = MD_RUN;
                    cnt_d      = ((MDOpE == MD_MULT) || (MDOpE == MD_MULTU)) ?
                                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    pendHi_d   = resHi;
                    pendLo_d   = resLo;
                    pendZero_d = divZero;
                end else if (MDOpE == MD_MTHI) begin
                    hi_d = AE;
                end else if (MDOpE == MD_MTLO) begin
                    lo_d = AE;
                end
            end
            MD_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (!pendZero_q) begin
                        hi_d = pendHi_q;
                        lo_d = pendLo_q;
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign Busy    = (state_q == MD_RUN);
    assign StallMD = MDUseD & (Busy | isStart);
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios followed by random ops,
// all compared against a cycle-level behavioural model of HI/LO and busy time.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [2:0]  MDOpE;
    logic [31:0] AE;
    logic [31:0] BE;
    logic        MDUseD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        StallMD;

    int compared;
    int mismatched;

    // Model state: architectural HI/LO, cycles of busy left, pending result.
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          remBusy;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        pendSkip;

    md_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .MDOpE   (MDOpE),
        .AE      (AE),
        .BE      (BE),
        .MDUseD  (MDUseD),
        .HI      (HI),
        .LO      (LO),
        .Busy    (Busy),
        .StallMD (StallMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, wanted %h", tag, act, exp);
        end
    endtask

    // Architectural results straight from the MIPS definitions, in 64-bit math.
    task automatic refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rHi, output logic [31:0] rLo, output logic skip);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        skip = 1'b0;
        rHi  = 32'd0;
        rLo  = 32'd0;
        case (op)
            MD_MULT: begin
                p   = 64'(sa * sb);
                rHi = p[63:32];
                rLo = p[31:0];
            end
            MD_MULTU: begin
                p   = {32'd0, a} * {32'd0, b};
                rHi = p[63:32];
                rLo = p[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) skip = 1'b1;
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    rHi = r[31:0];
                    rLo = q[31:0];
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) skip = 1'b1;
                else begin
                    rHi = a % b;
                    rLo = a / b;
                end
            end
            default: skip = 1'b1;
        endcase
    endtask

    // One clock cycle: drive inputs, check outputs before the edge, then
    // advance the model across the edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic use_, input logic rst);
        logic startOp;
        MDOpE   = op;
        AE      = a;
        BE      = b;
        MDUseD  = use_;
        reset   = rst;
        startOp = (op >= 3'd1) && (op <= 3'd4);
        @(negedge clk);
        checkOutput("Busy", {31'd0, Busy}, {31'd0, remBusy > 0});
        checkOutput("StallMD", {31'd0, StallMD}, {31'd0, use_ && (remBusy > 0 || startOp)});
        checkOutput("HI", HI, expHi);
        checkOutput("LO", LO, expLo);
        @(posedge clk);
        #1;
        if (rst) begin
            expHi = 0; expLo = 0; remBusy = 0; pendHi = 0; pendLo = 0; pendSkip = 0;
        end else if (remBusy > 0) begin
            remBusy--;
            if (remBusy == 0 && !pendSkip) begin
                expHi = pendHi;
                expLo = pendLo;
            end
        end else if (startOp) begin
            refResult(op, a, b, pendHi, pendLo, pendSkip);
            remBusy = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
        end else if (op == MD_MTHI) begin
            expHi = a;
        end else if (op == MD_MTLO) begin
            expLo = a;
        end
    endtask

    task automatic idleCycles(input int n, input logic use_);
        for (int i = 0; i < n; i++) applyStimulus(MD_NONE, 32'd0, 32'd0, use_, 1'b0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 20));
            4: return 32'(-int'($urandom_range(1, 20)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int busyCount;
        compared   = 0;
        mismatched = 0;
        expHi = 0; expLo = 0; remBusy = 0; pendHi = 0; pendLo = 0; pendSkip = 0;
        MDOpE = MD_NONE; AE = 0; BE = 0; MDUseD = 0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        checkOutput("reset Busy", {31'd0, Busy}, 32'd0);
        applyStimulus(MD_NONE, 0, 0, 1'b0, 1'b0);

        // Signed mult with MDUseD held: stall in start cycle and 5 busy cycles.
        busyCount = 0;
        applyStimulus(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (Busy) busyCount++;
            applyStimulus(MD_NONE, 0, 0, 1'b1, 1'b0);
        end
        checkOutput("mult busy len", busyCount, MULT_N);
        checkOutput("mult HI", HI, 32'hFFFFFFFF);
        checkOutput("mult LO", LO, 32'hFFFFFFFE);

        applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        idleCycles(MULT_N + 1, 1'b0);
        checkOutput("multu HI", HI, 32'h00000001);
        checkOutput("multu LO", LO, 32'hFFFFFFFE);

        busyCount = 0;
        applyStimulus(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < DIV_N + 2; i++) begin
            if (Busy) busyCount++;
            applyStimulus(MD_NONE, 0, 0, 1'b0, 1'b0);
        end
        checkOutput("divu busy len", busyCount, DIV_N);
        checkOutput("divu HI", HI, 32'd1);
        checkOutput("divu LO", LO, 32'd3);

        applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        idleCycles(DIV_N + 1, 1'b0);
        checkOutput("div HI", HI, 32'hFFFFFFFF);
        checkOutput("div LO", LO, 32'hFFFFFFFD);

        applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        idleCycles(DIV_N + 1, 1'b0);
        checkOutput("div ovf HI", HI, 32'd0);
        checkOutput("div ovf LO", LO, 32'h80000000);

        // Divide by zero leaves preloaded HI/LO untouched.
        applyStimulus(MD_MTHI, 32'h11, 0, 1'b0, 1'b0);
        checkOutput("mthi HI", HI, 32'h11);
        applyStimulus(MD_MTLO, 32'h22, 0, 1'b0, 1'b0);
        checkOutput("mtlo LO", LO, 32'h22);
        applyStimulus(MD_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
        idleCycles(DIV_N + 1, 1'b0);
        checkOutput("div0 HI", HI, 32'h11);
        checkOutput("div0 LO", LO, 32'h22);

        // Starts and moves issued while busy must be ignored.
        applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
        applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        applyStimulus(MD_MTHI, 32'hDEAD, 0, 1'b1, 1'b0);
        applyStimulus(MD_MTLO, 32'hBEEF, 0, 1'b1, 1'b0);
        idleCycles(MULT_N, 1'b1);
        checkOutput("ignored HI", HI, 32'd0);
        checkOutput("ignored LO", LO, 32'd12);
        checkOutput("ignored Busy", {31'd0, Busy}, 32'd0);

        // Reset in the third busy cycle aborts the commit.
        applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(MD_NONE, 0, 0, 1'b0, 1'b1);
        checkOutput("abort Busy", {31'd0, Busy}, 32'd0);
        idleCycles(MULT_N + 2, 1'b0);
        checkOutput("abort LO", LO, 32'd0);

        for (int i = 0; i < 800; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
        end
        idleCycles(DIV_N + 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
